sh7034_ext_target: RTL and testbench
====================================

// Module: sh7034_ext_target
// PURPOSE
//   Responder for the SH7034 external bus: decodes one CS_N area, accepts reads/writes driven by the
//   CPU bus state controller, forwards each as a single request to a synchronous memory/peripheral
//   port, and holds WAIT_N low until that port acknowledges. Sits between the CPU pins and SDRAM/BRAM.
// PARAMETERS
//   CS_IDX   0   index of CS_N line this target answers (0..7)
//   BUS16    1   1: 16-bit area (WRH_N/WRL_N lanes); 0: 8-bit area (data on bits 7:0, WRL_N only)
//   MEM_AW   23  width of MEM_A (halfword address, taken from A[MEM_AW:1])
//   TIMEOUT  255 CLK cycles to wait for MEM_ACK before forced completion (8-bit counter)
// PORTS
//   CLK      in   1       system clock
//   RST_N    in   1       asynchronous reset, active low
//   A        in   24      bus address from CPU
//   BUS_DI   in   16      write data from CPU (CPU DO)
//   BUS_DO   out  16      read data to CPU (CPU DI), registered
//   CS_N     in   8       area chip selects, active low
//   RD_N     in   1       read strobe, active low
//   WRH_N    in   1       upper-byte write strobe, active low
//   WRL_N    in   1       lower-byte write strobe, active low
//   WAIT_N   out  1       wait request to CPU, active low, registered
//   MEM_A    out  MEM_AW  halfword address to memory
//   MEM_DO   out  16      write data to memory
//   MEM_BE   out  2       byte enables {hi,lo}
//   MEM_WE   out  1       1 = write, 0 = read
//   MEM_REQ  out  1       request, level; held until MEM_ACK
//   MEM_DI   in   16      read data from memory, valid with MEM_ACK
//   MEM_ACK  in   1       one-CLK completion pulse
//   ERR      out  1       one-CLK pulse on timeout
// BEHAVIOUR
//   Reset: WAIT_N=1, BUS_DO=0, MEM_REQ=0, MEM_WE=0, MEM_A=0, MEM_BE=0, MEM_DO=0, ERR=0, state IDLE,
//     timeout counter 0. Async reset mid-transaction aborts it; outstanding MEM_ACK afterwards ignored.
//   Strobe active: STB = ~CS_N[CS_IDX] & (~RD_N | ~WRH_N | ~WRL_N). Write wins if RD_N and a WR both low.
//   IDLE: STB sampled every CLK. On STB: latch A, BUS_DI, strobes into MEM_* ; MEM_REQ<=1, WAIT_N<=0,
//     counter<=0 -> REQ. Latency: MEM_REQ and WAIT_N change 1 CLK after STB seen.
//   Lanes BUS16=1: write MEM_BE={~WRH_N,~WRL_N}, MEM_DO=BUS_DI; read MEM_BE=2'b11.
//   Lanes BUS16=0: big-endian; A[0]=0 -> MEM_BE=2'b10, A[0]=1 -> 2'b01; MEM_DO={BUS_DI[7:0],BUS_DI[7:0]};
//     read returns selected byte on BUS_DO[7:0], BUS_DO[15:8]=0.
//   REQ: MEM_REQ held, inputs ignored. Counter +1 per CLK.
//     MEM_ACK: MEM_REQ<=0, WAIT_N<=1, on read BUS_DO<=lane-selected MEM_DI -> HOLD.
//     counter==TIMEOUT with no ACK: MEM_REQ<=0, WAIT_N<=1, ERR<=1 (1 CLK), read BUS_DO<=16'hFFFF -> HOLD.
//     ACK and timeout same cycle: ACK wins, no ERR.
//   HOLD: BUS_DO stable. Exit to IDLE when all of RD_N, WRH_N, WRL_N high OR CS_N[CS_IDX] high
//     (CPU keeps CS_N low across back-to-back halves; strobe release alone ends the access).
//     New STB only recognised from IDLE, so each strobe assertion yields exactly one MEM_REQ.
//   CS_N deasserted while in REQ: request still completes; then HOLD exits immediately to IDLE.
//   BUS_DO holds last read value until next read completes; writes do not change it.
//   WAIT_N low for >=1 CLK per access; CPU samples it on its CE_R in TW, so ACK-to-release is 1 CLK.
//   Other CS_N lines and strobes for other areas: no effect, no outputs change.
// TESTING
//   1. BUS16=1, read A=24'h000100, MEM_ACK 3 CLK after MEM_REQ, MEM_DI=16'hBEEF -> MEM_A=0x80,
//      MEM_BE=11, MEM_WE=0, WAIT_N low 3 CLK then high, BUS_DO=16'hBEEF.
//   2. BUS16=1, write WRL_N=0 only, BUS_DI=16'h1234, A=24'h000002 -> MEM_WE=1, MEM_BE=01,
//      MEM_DO=16'h1234, MEM_A=1, BUS_DO unchanged.
//   3. BUS16=0, read A=24'h000003, MEM_DI=16'hAA55 -> MEM_BE=01, BUS_DO=16'h0055; A=...02 -> 16'h00AA.
//   4. CS_N held low, RD_N pulsed twice (A=0x10 then 0x12) -> exactly two MEM_REQ, BUS_DO tracks each.
//   5. TIMEOUT=16, no MEM_ACK -> WAIT_N releases after 16 CLK, ERR 1-CLK pulse, BUS_DO=16'hFFFF;
//      ACK on cycle 16 instead -> no ERR, BUS_DO=MEM_DI.
//   6. RST_N low while in REQ -> all outputs to reset values, WAIT_N=1; late MEM_ACK -> no change.

Source files
------------

// File: rtl/sh7034_ext_target.sv
`default_nettype none
// sh7034_ext_target: SH7034 external-bus responder for one CS_N area. Each strobe assertion
// becomes one MEM_REQ/MEM_ACK handshake, and WAIT_N stays low until that handshake completes.
module sh7034_ext_target #(
  parameter int CS_IDX  = 0,
  parameter int BUS16   = 1,
  parameter int MEM_AW  = 23,
  parameter int TIMEOUT = 255
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [23:0]       A,
  input  logic [15:0]       BUS_DI,
  output logic [15:0]       BUS_DO,
  input  logic [7:0]        CS_N,
  input  logic              RD_N,
  input  logic              WRH_N,
  input  logic              WRL_N,
  output logic              WAIT_N,
  output logic [MEM_AW-1:0] MEM_A,
  output logic [15:0]       MEM_DO,
  output logic [1:0]        MEM_BE,
  output logic              MEM_WE,
  output logic              MEM_REQ,
  input  logic [15:0]       MEM_DI,
  input  logic              MEM_ACK,
  output logic              ERR
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  localparam logic [2:0] C_CS      = 3'(CS_IDX);
  localparam logic [7:0] C_TO_LAST = 8'(TIMEOUT - 1);

  state_t              r_state, w_state_nxt;
  logic [7:0]          r_cnt, w_cnt_nxt;
  logic [15:0]         r_bus_do, w_bus_do_nxt;
  logic                r_wait_n, w_wait_n_nxt;
  logic [MEM_AW-1:0]   r_mem_a, w_mem_a_nxt;
  logic [15:0]         r_mem_do, w_mem_do_nxt;
  logic [1:0]          r_mem_be, w_mem_be_nxt;
  logic                r_mem_we, w_mem_we_nxt;
  logic                r_mem_req, w_mem_req_nxt;
  logic                r_err, w_err_nxt;
  logic                r_lane, w_lane_nxt;

  logic                w_stb, w_wr, w_release;
  logic [15:0]         w_rd_data;

  assign w_wr      = ~WRH_N | ~WRL_N;
  assign w_stb     = ~CS_N[C_CS] & (~RD_N | w_wr);
  assign w_release = (RD_N & WRH_N & WRL_N) | CS_N[C_CS];

  // Narrow area is big-endian: even byte address lives on the upper half of the memory word.
  assign w_rd_data = (BUS16 != 0) ? MEM_DI
                   : (r_lane ? {8'h00, MEM_DI[7:0]} : {8'h00, MEM_DI[15:8]});

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_bus_do_nxt  = r_bus_do;
    w_wait_n_nxt  = r_wait_n;
    w_mem_a_nxt   = r_mem_a;
    w_mem_do_nxt  = r_mem_do;
    w_mem_be_nxt  = r_mem_be;
    w_mem_we_nxt  = r_mem_we;
    w_mem_req_nxt = r_mem_req;
    w_err_nxt     = 1'b0;
    w_lane_nxt    = r_lane;
    case (r_state)
      S_IDLE: begin
        if (w_stb) begin
          w_state_nxt   = S_REQ;
          w_cnt_nxt     = 8'd0;
          w_mem_req_nxt = 1'b1;
          w_wait_n_nxt  = 1'b0;
          w_mem_a_nxt   = A[MEM_AW:1];
          w_mem_we_nxt  = w_wr;
          w_lane_nxt    = A[0];
          if (BUS16 != 0) begin
            w_mem_be_nxt = w_wr ? {~WRH_N, ~WRL_N} : 2'b11;
            w_mem_do_nxt = BUS_DI;
          end else begin
            w_mem_be_nxt = A[0] ? 2'b01 : 2'b10;
            w_mem_do_nxt = {BUS_DI[7:0], BUS_DI[7:0]};
          end
        end
      end
      S_REQ: begin
        w_cnt_nxt = r_cnt + 8'd1;
        // An acknowledge arriving on the timeout cycle still counts as a normal completion.
        if (MEM_ACK) begin
          w_state_nxt   = S_HOLD;
          w_mem_req_nxt = 1'b0;
          w_wait_n_nxt  = 1'b1;
          if (!r_mem_we) w_bus_do_nxt = w_rd_data;
        end else if (r_cnt == C_TO_LAST) begin
          w_state_nxt   = S_HOLD;
          w_mem_req_nxt = 1'b0;
          w_wait_n_nxt  = 1'b1;
          w_err_nxt     = 1'b1;
          if (!r_mem_we) w_bus_do_nxt = 16'hFFFF;
        end
      end
      S_HOLD: begin
        if (w_release) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state   <= S_IDLE;
      r_cnt     <= 8'd0;
      r_bus_do  <= 16'h0000;
      r_wait_n  <= 1'b1;
      r_mem_a   <= '0;
      r_mem_do  <= 16'h0000;
      r_mem_be  <= 2'b00;
      r_mem_we  <= 1'b0;
      r_mem_req <= 1'b0;
      r_err     <= 1'b0;
      r_lane    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_bus_do  <= w_bus_do_nxt;
      r_wait_n  <= w_wait_n_nxt;
      r_mem_a   <= w_mem_a_nxt;
      r_mem_do  <= w_mem_do_nxt;
      r_mem_be  <= w_mem_be_nxt;
      r_mem_we  <= w_mem_we_nxt;
      r_mem_req <= w_mem_req_nxt;
      r_err     <= w_err_nxt;
      r_lane    <= w_lane_nxt;
    end
  end

  assign BUS_DO  = r_bus_do;
  assign WAIT_N  = r_wait_n;
  assign MEM_A   = r_mem_a;
  assign MEM_DO  = r_mem_do;
  assign MEM_BE  = r_mem_be;
  assign MEM_WE  = r_mem_we;
  assign MEM_REQ = r_mem_req;
  assign ERR     = r_err;

endmodule
`default_nettype wire

// File: tb/tb_sh7034_ext_target.sv
`default_nettype none
// tb_sh7034_ext_target: directed checks of a 16-bit target on CS0 and an 8-bit target on CS1.
module tb_sh7034_ext_target;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic [23:0] A = 24'h0;
  logic [15:0] BUS_DI = 16'h0;
  logic [7:0]  CS_N = 8'hFF;
  logic        RD_N = 1'b1, WRH_N = 1'b1, WRL_N = 1'b1;

  logic [15:0] w_bus_do, n_bus_do, w_mem_do, n_mem_do;
  logic        w_wait_n, n_wait_n, w_we, n_we, w_req, n_req, w_err, n_err;
  logic [22:0] w_mem_a, n_mem_a;
  logic [1:0]  w_be, n_be;
  logic [15:0] w_di = 16'h0, n_di = 16'h0;
  logic        w_ack = 1'b0, n_ack = 1'b0;

  int total = 0;
  int bad = 0;
  int rise_w = 0;
  int lowcnt;
  int r0;

  always #5 CLK = ~CLK;
  always @(posedge w_req) rise_w++;

  sh7034_ext_target #(.CS_IDX(0), .BUS16(1), .MEM_AW(23), .TIMEOUT(16)) u_wide (
    .CLK(CLK), .RST_N(RST_N), .A(A), .BUS_DI(BUS_DI), .BUS_DO(w_bus_do), .CS_N(CS_N),
    .RD_N(RD_N), .WRH_N(WRH_N), .WRL_N(WRL_N), .WAIT_N(w_wait_n), .MEM_A(w_mem_a),
    .MEM_DO(w_mem_do), .MEM_BE(w_be), .MEM_WE(w_we), .MEM_REQ(w_req), .MEM_DI(w_di),
    .MEM_ACK(w_ack), .ERR(w_err)
  );

  sh7034_ext_target #(.CS_IDX(1), .BUS16(0), .MEM_AW(23), .TIMEOUT(16)) u_narrow (
    .CLK(CLK), .RST_N(RST_N), .A(A), .BUS_DI(BUS_DI), .BUS_DO(n_bus_do), .CS_N(CS_N),
    .RD_N(RD_N), .WRH_N(WRH_N), .WRL_N(WRL_N), .WAIT_N(n_wait_n), .MEM_A(n_mem_a),
    .MEM_DO(n_mem_do), .MEM_BE(n_be), .MEM_WE(n_we), .MEM_REQ(n_req), .MEM_DI(n_di),
    .MEM_ACK(n_ack), .ERR(n_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge CLK);
  endtask

  task automatic bus_idle();
    CS_N = 8'hFF; RD_N = 1'b1; WRH_N = 1'b1; WRL_N = 1'b1;
  endtask

  initial begin
    // reset values
    #12;
    chk("rst_wait_n", {31'd0, w_wait_n}, 32'd1);
    chk("rst_req",    {31'd0, w_req},    32'd0);
    chk("rst_bus_do", {16'd0, w_bus_do}, 32'h0);
    chk("rst_be_we",  {29'd0, w_be, w_we}, 32'd0);
    chk("rst_err",    {31'd0, w_err},    32'd0);
    step();
    RST_N = 1'b1;
    step();

    // 1: 16-bit read, ack 3 clocks after request
    A = 24'h000100; CS_N = 8'hFE; RD_N = 1'b0;
    step();
    chk("t1_req",   {31'd0, w_req},  32'd1);
    chk("t1_mem_a", {9'd0, w_mem_a}, 32'h80);
    chk("t1_be",    {30'd0, w_be},   32'd3);
    chk("t1_we",    {31'd0, w_we},   32'd0);
    chk("t1_narrow_idle", {31'd0, n_req}, 32'd0);
    lowcnt = (w_wait_n == 1'b0) ? 1 : 0;
    step();
    lowcnt += (w_wait_n == 1'b0) ? 1 : 0;
    step();
    lowcnt += (w_wait_n == 1'b0) ? 1 : 0;
    w_ack = 1'b1; w_di = 16'hBEEF;
    step();
    w_ack = 1'b0;
    chk("t1_wait_low_cycles", lowcnt, 32'd3);
    chk("t1_wait_release", {31'd0, w_wait_n}, 32'd1);
    chk("t1_req_drop", {31'd0, w_req}, 32'd0);
    chk("t1_bus_do", {16'd0, w_bus_do}, 32'hBEEF);
    bus_idle();
    step();

    // 2: 16-bit low-byte write
    A = 24'h000002; BUS_DI = 16'h1234; CS_N = 8'hFE; WRL_N = 1'b0;
    step();
    chk("t2_we",     {31'd0, w_we},     32'd1);
    chk("t2_be",     {30'd0, w_be},     32'd1);
    chk("t2_mem_do", {16'd0, w_mem_do}, 32'h1234);
    chk("t2_mem_a",  {9'd0, w_mem_a},   32'h1);
    w_ack = 1'b1; w_di = 16'h7777;
    step();
    w_ack = 1'b0;
    chk("t2_bus_do_kept", {16'd0, w_bus_do}, 32'hBEEF);
    chk("t2_wait_n", {31'd0, w_wait_n}, 32'd1);
    bus_idle();
    step();

    // 3: 8-bit reads, odd then even byte
    A = 24'h000003; CS_N = 8'hFD; RD_N = 1'b0;
    step();
    chk("t3_odd_be", {30'd0, n_be}, 32'd1);
    chk("t3_wide_idle", {31'd0, w_req}, 32'd0);
    n_ack = 1'b1; n_di = 16'hAA55;
    step();
    n_ack = 1'b0;
    chk("t3_odd_data", {16'd0, n_bus_do}, 32'h0055);
    bus_idle();
    step();
    A = 24'h000002; CS_N = 8'hFD; RD_N = 1'b0;
    step();
    chk("t3_even_be", {30'd0, n_be}, 32'd2);
    n_ack = 1'b1;
    step();
    n_ack = 1'b0;
    chk("t3_even_data", {16'd0, n_bus_do}, 32'h00AA);
    bus_idle();
    step();
    // 8-bit write replicates the byte on both lanes
    A = 24'h000004; BUS_DI = 16'h9912; CS_N = 8'hFD; WRL_N = 1'b0;
    step();
    chk("t3_wr_do", {16'd0, n_mem_do}, 32'h1212);
    chk("t3_wr_be", {30'd0, n_be}, 32'd2);
    n_ack = 1'b1;
    step();
    n_ack = 1'b0;
    chk("t3_wr_bus_do_kept", {16'd0, n_bus_do}, 32'h00AA);
    bus_idle();
    step();

    // other area strobed: nobody responds
    CS_N = 8'h7F; RD_N = 1'b0;
    step();
    step();
    chk("other_cs_wide", {31'd0, w_req}, 32'd0);
    chk("other_cs_narrow", {31'd0, n_req}, 32'd0);
    bus_idle();
    step();

    // 4: CS held low, two read pulses
    r0 = rise_w;
    A = 24'h000010; CS_N = 8'hFE; RD_N = 1'b0;
    step();
    chk("t4_a1", {9'd0, w_mem_a}, 32'h8);
    w_ack = 1'b1; w_di = 16'h1111;
    step();
    w_ack = 1'b0;
    chk("t4_d1", {16'd0, w_bus_do}, 32'h1111);
    step();
    chk("t4_no_retrigger", {31'd0, w_req}, 32'd0);
    RD_N = 1'b1;
    step();
    A = 24'h000012; RD_N = 1'b0;
    step();
    chk("t4_a2", {9'd0, w_mem_a}, 32'h9);
    w_ack = 1'b1; w_di = 16'h2222;
    step();
    w_ack = 1'b0;
    chk("t4_d2", {16'd0, w_bus_do}, 32'h2222);
    chk("t4_two_reqs", rise_w - r0, 32'd2);
    bus_idle();
    step();

    // 5a: timeout with no ack
    A = 24'h000020; CS_N = 8'hFE; RD_N = 1'b0;
    lowcnt = 0;
    for (int i = 0; i < 16; i++) begin
      step();
      lowcnt += (w_wait_n == 1'b0) ? 1 : 0;
    end
    chk("t5_wait_low_16", lowcnt, 32'd16);
    step();
    chk("t5_wait_release", {31'd0, w_wait_n}, 32'd1);
    chk("t5_err_pulse", {31'd0, w_err}, 32'd1);
    chk("t5_bus_do_ffff", {16'd0, w_bus_do}, 32'hFFFF);
    step();
    chk("t5_err_one_clk", {31'd0, w_err}, 32'd0);
    bus_idle();
    step();

    // 5b: ack on the timeout cycle wins
    A = 24'h000020; CS_N = 8'hFE; RD_N = 1'b0;
    for (int i = 0; i < 16; i++) step();
    w_ack = 1'b1; w_di = 16'h5A5A;
    step();
    w_ack = 1'b0;
    chk("t5b_no_err", {31'd0, w_err}, 32'd0);
    chk("t5b_wait_n", {31'd0, w_wait_n}, 32'd1);
    chk("t5b_bus_do", {16'd0, w_bus_do}, 32'h5A5A);
    step();
    chk("t5b_no_err_late", {31'd0, w_err}, 32'd0);
    bus_idle();
    step();

    // 6: async reset in REQ, then a late ack
    A = 24'h000040; CS_N = 8'hFE; RD_N = 1'b0;
    step();
    chk("t6_in_req", {31'd0, w_req}, 32'd1);
    #2 RST_N = 1'b0;
    #1;
    chk("t6_rst_wait_n", {31'd0, w_wait_n}, 32'd1);
    chk("t6_rst_req",    {31'd0, w_req},    32'd0);
    chk("t6_rst_bus_do", {16'd0, w_bus_do}, 32'h0);
    chk("t6_rst_mem_a",  {9'd0, w_mem_a},   32'h0);
    chk("t6_rst_be_we",  {29'd0, w_be, w_we}, 32'd0);
    chk("t6_rst_narrow_do", {16'd0, n_bus_do}, 32'h0);
    bus_idle();
    step();
    RST_N = 1'b1;
    step();
    w_ack = 1'b1; w_di = 16'hDEAD;
    step();
    w_ack = 1'b0;
    step();
    chk("t6_late_ack_req",    {31'd0, w_req},    32'd0);
    chk("t6_late_ack_wait",   {31'd0, w_wait_n}, 32'd1);
    chk("t6_late_ack_bus_do", {16'd0, w_bus_do}, 32'h0);
    chk("t6_late_ack_err",    {31'd0, w_err},    32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
